// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: requester count,
// select width, FSM state type and the rotating priority pick function.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Return the first requester with its bit set, scanning ptr, ptr+1, ...
  // ptr+7 (the 3-bit add wraps mod 8). Falls back to ptr when nothing is set;
  // callers only use the result when req is non-zero.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux8_word.sv
// WIDTH-bit 8:1 word multiplexer. Word i lives at din[i*WIDTH +: WIDTH].
module mux8_word
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [NUM_REQ*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         dout
);

  // Select the addressed word.
  always_comb begin
    dout = din[32'(sel)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one WIDTH-bit bus between 8 requesters.
// A grant is held until its owner drops req; every handover costs one idle
// cycle. Optional macro ARB_TIMEOUT_EN: an owner that has held the bus for
// MAX_HOLD cycles is forced off when another requester is waiting.
//
// Handshake: req[i] is a level request; grant[i] high means requester i owns
// the bus this cycle and dout carries din word i. dout_valid mirrors |grant.
// The owner ends its tenure by dropping req[i]; the grant falls after the
// next rising edge.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]       grant,
  output logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid
);

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // With the timeout, the hold counter parks at the limit; otherwise at 255.
  localparam logic [7:0] HOLD_CAP = TIMEOUT_ON ? 8'(MAX_HOLD) : 8'hFF;

  arb_state_t       state;
  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [SEL_W-1:0] pick;
  logic             others_waiting;
  logic             release_now;
  logic [WIDTH-1:0] mux_out;

  // Next owner candidate and end-of-tenure decision for the current owner.
  always_comb begin
    pick           = rr_pick(req, ptr);
    others_waiting = |(req & ~grant);
    release_now    = !req[owner] ||
                     (TIMEOUT_ON && (hold_cnt == HOLD_CAP) && others_waiting);
  end

  // Arbitration FSM: all outputs registered, reset drops the grant at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      grant    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= pick;
            grant    <= NUM_REQ'(1) << pick;
            hold_cnt <= 8'd1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant <= '0;
            ptr   <= owner + SEL_W'(1);
            state <= IDLE;
          end else if (hold_cnt != HOLD_CAP) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign sel        = owner;
  assign dout_valid = |grant;

  mux8_word #(.WIDTH(WIDTH)) u_mux (
    .din  (din),
    .sel  (owner),
    .dout (mux_out)
  );

  // Only a granted word reaches the shared bus.
  always_comb begin
    dout = dout_valid ? mux_out : '0;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed plus randomized bench for rr_arbiter8 against a cycle-level model
// of the arbitration rules (busy flag, owner, rotating pointer, hold count).
module tb_rr_arbiter8;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           req;
  logic [8*WIDTH-1:0]   din;
  logic [7:0]           grant;
  logic [2:0]           sel;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;

  rr_arbiter8 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .grant      (grant),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [8*WIDTH-1:0] rand_din();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One rising edge of the arbitration rules, given the sampled requests.
  task automatic model_clock(input logic [7:0] r);
    bit rel;
    int cap;
    int idx;
`ifdef ARB_TIMEOUT_EN
    cap = MAX_HOLD;
`else
    cap = 255;
`endif
    if (!m_busy) begin
      if (r != 8'h00) begin
        for (int k = 7; k >= 0; k--) begin
          idx = (m_ptr + k) % 8;
          if (r[idx]) m_owner = idx;
        end
        m_busy = 1'b1;
        m_hold = 1;
      end
    end else begin
      rel = (r[m_owner] == 1'b0);
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MAX_HOLD && (r & ~(8'(1) << m_owner)) != 8'h00) rel = 1'b1;
`endif
      if (rel) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 8;
      end else if (m_hold < cap) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0]       eg;
    logic [WIDTH-1:0] ed;
    eg = m_busy ? (8'(1) << m_owner) : 8'h00;
    ed = m_busy ? din[m_owner*WIDTH +: WIDTH] : '0;
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".sel"}, 32'(sel), 32'(m_owner));
    check({tag, ".dout"}, 32'(dout), 32'(ed));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_busy));
  endtask

  // Drive one cycle of stimulus, advance model and DUT, check just after the edge.
  task automatic step(input string tag, input logic [7:0] r, input logic [8*WIDTH-1:0] d);
    req = r;
    din = d;
    @(posedge clk);
    model_clock(r);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [8*WIDTH-1:0] d;
    logic [7:0]         r;

    // Power-on reset
    rst = 1'b1;
    req = 8'h00;
    din = '0;
    model_reset();
    #1;
    check_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Single requester 3 with a known word
    d = rand_din();
    d[3*WIDTH +: WIDTH] = 8'hA5;
    step("single", 8'h08, d);
    check("single.grant_08", 32'(grant), 32'h08);
    check("single.sel_3", 32'(sel), 32'd3);
    check("single.dout_a5", 32'(dout), 32'hA5);
    step("single_drop", 8'h00, rand_din());
    check("single_drop.grant_0", 32'(grant), 32'h00);
    for (int i = 0; i < 3; i++) step("idle", 8'h00, rand_din());

    // Full rotation with single-cycle holds
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step("rr_grant", 8'hFF, rand_din());
      check("rr_order", 32'(sel), 32'(i % 8));
      step("rr_dead", 8'hFF & ~(8'(1) << m_owner), rand_din());
      check("rr_dead_valid", 32'(dout_valid), 32'd0);
    end

    // Pointer wrap past 7 and re-grant of the same requester
    do_reset();
    step("wrap6", 8'h40, rand_din());
    step("wrap6_rel", 8'h03, rand_din());
    step("wrap_to0", 8'h03, rand_din());
    check("wrap_to0.grant", 32'(grant), 32'h01);
    step("wrap0_rel", 8'h00, rand_din());
    step("own7", 8'h80, rand_din());
    check("own7.grant", 32'(grant), 32'h80);
    step("own7_rel", 8'h00, rand_din());
    step("own7_again", 8'h80, rand_din());
    check("own7_again.grant", 32'(grant), 32'h80);
    step("own7_rel2", 8'h00, rand_din());

`ifdef ARB_TIMEOUT_EN
    // Forced rotation after MAX_HOLD grant cycles
    step("to_grant1", 8'h02, rand_din());
    check("to_grant1.grant", 32'(grant), 32'h02);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      step("to_hold", 8'h22, rand_din());
      check("to_hold.grant", 32'(grant), 32'h02);
    end
    step("to_drop", 8'h22, rand_din());
    check("to_drop.grant", 32'(grant), 32'h00);
    step("to_next", 8'h22, rand_din());
    check("to_next.grant", 32'(grant), 32'h20);
    step("to_rel5", 8'h02, rand_din());
    step("to_alone", 8'h02, rand_din());
    for (int i = 0; i < 20; i++) begin
      step("to_alone_hold", 8'h02, rand_din());
      check("to_alone_hold.grant", 32'(grant), 32'h02);
    end
    step("to_alone_rel", 8'h00, rand_din());
`else
    // No preemption: owner 2 keeps the bus while requester 0 waits
    step("np_grant2", 8'h04, rand_din());
    check("np_grant2.grant", 32'(grant), 32'h04);
    for (int i = 0; i < 40; i++) begin
      step("np_hold", 8'h05, rand_din());
      check("np_hold.grant", 32'(grant), 32'h04);
    end
    step("np_rel", 8'h01, rand_din());
    check("np_rel.grant", 32'(grant), 32'h00);
    step("np_next", 8'h01, rand_din());
    check("np_next.grant", 32'(grant), 32'h01);
    step("np_next_rel", 8'h00, rand_din());
`endif

    // Asynchronous reset in the middle of a grant
    do_reset();
    step("ar_grant", 8'h04, rand_din());
    check("ar_grant.grant", 32'(grant), 32'h04);
    rst = 1'b1;
    #1;
    model_reset();
    check("ar_now.grant", 32'(grant), 32'h00);
    check("ar_now.sel", 32'(sel), 32'd0);
    check("ar_now.dout", 32'(dout), 32'd0);
    check_outputs("ar_now");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("ar_after", 8'h00, rand_din());

    // Randomized traffic with sticky requests so holds of varying length occur
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       r = 8'($urandom_range(0, 255));
        1:       r = r ^ (8'(1) << $urandom_range(0, 7));
        2:       r = r & ~(8'(1) << m_owner);
        default: r = r;
      endcase
      step("rand", r, rand_din());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
